// File: rtl/seq_detect_ctrl.sv
// Word-fed serial pattern detector: accepts words over valid/ready, shifts them MSB-first
// through a programmable pattern matcher, and reports match position plus a saturating count.
module seq_detect_ctrl #(
    parameter int WORD_W = 8,
    parameter int PAT_W  = 4,
    parameter int CNT_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_we,
    input  logic [PAT_W-1:0]          cfg_pattern,
    input  logic                      cfg_overlap,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [WORD_W-1:0]         s_data,
    input  logic                      s_last,
    input  logic                      cnt_clr,
    output logic                      match,
    output logic [$clog2(WORD_W)-1:0] match_pos,
    output logic [CNT_W-1:0]          match_count,
    output logic                      busy
);

    localparam int POS_W  = $clog2(WORD_W);
    localparam int FILL_W = $clog2(PAT_W + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t              state_q;
    logic [WORD_W-1:0]   sreg_q;
    logic [POS_W-1:0]    idx_q;
    logic                last_q;
    logic [PAT_W-1:0]    pat_q;
    logic                ovl_q;
    logic [PAT_W-1:0]    hist_q;
    logic [FILL_W-1:0]   fill_q;
    logic                match_q;
    logic [POS_W-1:0]    pos_q;
    logic [CNT_W-1:0]    cnt_q;

    logic                bit_c;
    logic [PAT_W-1:0]    hist_d;
    logic [FILL_W-1:0]   fill_d;
    logic                hit;
    logic                word_end;
    logic                cnt_sat;

    always_comb begin
        bit_c    = sreg_q[WORD_W-1];
        hist_d   = (hist_q << 1) | PAT_W'(bit_c);
        fill_d   = (fill_q == FILL_W'(PAT_W)) ? fill_q : fill_q + FILL_W'(1);
        hit      = (state_q == SHIFT) && (fill_d == FILL_W'(PAT_W)) && (hist_d == pat_q);
        word_end = (idx_q == POS_W'(WORD_W - 1));
        cnt_sat  = &cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            pat_q   <= PAT_W'(4'b1010);
            ovl_q   <= 1'b1;
            hist_q  <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
            pos_q   <= '0;
            cnt_q   <= '0;
        end else begin
            match_q <= 1'b0;
            // Clear beats increment; the match pulse itself is unaffected.
            if (cnt_clr)
                cnt_q <= '0;
            else if (hit && !cnt_sat)
                cnt_q <= cnt_q + CNT_W'(1);

            case (state_q)
                IDLE: begin
                    if (cfg_we) begin
                        pat_q  <= cfg_pattern;
                        ovl_q  <= cfg_overlap;
                        hist_q <= '0;
                        fill_q <= '0;
                    end else if (s_valid) begin
                        sreg_q  <= s_data;
                        last_q  <= s_last;
                        idx_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    sreg_q <= sreg_q << 1;
                    idx_q  <= idx_q + POS_W'(1);
                    hist_q <= hist_d;
                    // Non-overlap mode forgets the completing bits so they cannot seed another hit.
                    fill_q <= (hit && !ovl_q) ? '0 : fill_d;
                    if (hit) begin
                        match_q <= 1'b1;
                        pos_q   <= idx_q;
                    end
                    if (word_end) begin
                        state_q <= IDLE;
                        if (last_q) begin
                            hist_q <= '0;
                            fill_q <= '0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s_ready     = rst && (state_q == IDLE) && !cfg_we;
    assign busy        = (state_q == SHIFT);
    assign match       = match_q;
    assign match_pos   = pos_q;
    assign match_count = cnt_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl: expected matches are queued as words are sent and
// a negedge monitor pops and compares them whenever the DUT pulses match.
module tb_seq_detect_ctrl;

    localparam int WORD_W = 8;
    localparam int PAT_W  = 4;
    localparam int POS_W  = $clog2(WORD_W);

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              cfg_we = 1'b0;
    logic [PAT_W-1:0]  cfg_pattern = '0;
    logic              cfg_overlap = 1'b0;
    logic              s_valid = 1'b0;
    logic [WORD_W-1:0] s_data = '0;
    logic              s_last = 1'b0;
    logic              cnt_clr = 1'b0;

    logic              s_ready, match, busy;
    logic [POS_W-1:0]  match_pos;
    logic [7:0]        match_count;

    logic              s_ready2, match2, busy2;
    logic [POS_W-1:0]  match_pos2;
    logic [1:0]        match_count2;

    int n_vec = 0;
    int n_err = 0;
    int exp_pos[$];
    int exp_cnt[$];

    seq_detect_ctrl #(.WORD_W(WORD_W), .PAT_W(PAT_W), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_overlap(cfg_overlap), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .cnt_clr(cnt_clr), .match(match),
        .match_pos(match_pos), .match_count(match_count), .busy(busy)
    );

    // Narrow-counter instance sharing the same stimulus, for saturation checks.
    seq_detect_ctrl #(.WORD_W(WORD_W), .PAT_W(PAT_W), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_overlap(cfg_overlap), .s_valid(s_valid), .s_ready(s_ready2),
        .s_data(s_data), .s_last(s_last), .cnt_clr(cnt_clr), .match(match2),
        .match_pos(match_pos2), .match_count(match_count2), .busy(busy2)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin : monitor
        int p, c;
        if (match) begin
            n_vec++;
            if (exp_pos.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_match got pos=%0d count=%0d", match_pos, match_count);
            end else begin
                p = exp_pos.pop_front();
                c = exp_cnt.pop_front();
                if (int'(match_pos) != p || int'(match_count) != c) begin
                    n_err++;
                    $display("FAIL match got pos=%0d count=%0d want pos=%0d count=%0d",
                             match_pos, match_count, p, c);
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic expect_m(input int pos, input int cnt);
        exp_pos.push_back(pos);
        exp_cnt.push_back(cnt);
    endtask

    task automatic do_cfg(input logic [PAT_W-1:0] pat, input logic ovl);
        cfg_we = 1'b1; cfg_pattern = pat; cfg_overlap = ovl;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic clear_cnt();
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        check("cnt_clr_idle", int'(match_count), 0);
    endtask

    // clr_e / cfg_e: pulse cnt_clr / a cfg write for edge E<k> after accept (0 = none).
    task automatic send_word(input logic [WORD_W-1:0] d, input logic l,
                             input int clr_e, input int cfg_e);
        int t;
        t = 0;
        while (!s_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!s_ready) begin
            n_vec++; n_err++;
            $display("FAIL ready_timeout got s_ready=0 want 1 within 50 cycles");
            return;
        end
        s_valid = 1'b1; s_data = d; s_last = l;
        @(negedge clk);
        s_valid = 1'b0; s_data = WORD_W'($urandom); s_last = 1'($urandom);
        for (int k = 1; k <= WORD_W; k++) begin
            cnt_clr = (k == clr_e);
            cfg_we  = (k == cfg_e);
            if (k == cfg_e) begin
                cfg_pattern = 4'b1010;
                cfg_overlap = 1'b0;
            end
            @(negedge clk);
            if (k == WORD_W - 1) begin
                check("busy_last_bit", int'(busy), 1);
                check("ready_last_bit", int'(s_ready), 0);
            end
        end
        cnt_clr = 1'b0;
        cfg_we  = 1'b0;
        check("ready_after_word", int'(s_ready), 1);
        check("busy_after_word", int'(busy), 0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", int'(s_ready), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_match", int'(match), 0);
        check("rst_pos", int'(match_pos), 0);
        check("rst_count", int'(match_count), 0);
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_rst", int'(s_ready), 1);

        // 1: default pattern 1010, overlap
        expect_m(3, 1); expect_m(5, 2); expect_m(7, 3);
        send_word(8'hAA, 1'b1, 0, 0);
        check("t1_count", int'(match_count), 3);

        // 2: non-overlap
        clear_cnt();
        do_cfg(4'b1010, 1'b0);
        expect_m(3, 1); expect_m(7, 2);
        send_word(8'hAA, 1'b1, 0, 0);
        check("t2_count", int'(match_count), 2);

        // 3: history across a word boundary, and cleared by s_last
        clear_cnt();
        expect_m(0, 1);
        send_word(8'h05, 1'b0, 0, 0);
        send_word(8'h00, 1'b1, 0, 0);
        send_word(8'h05, 1'b1, 0, 0);
        send_word(8'h00, 1'b1, 0, 0);
        check("t3_count", int'(match_count), 1);

        // 4: cfg write beats a word in IDLE; cfg write during SHIFT is ignored
        clear_cnt();
        cfg_we = 1'b1; cfg_pattern = 4'b0110; cfg_overlap = 1'b1;
        s_valid = 1'b1; s_data = 8'hAA; s_last = 1'b1;
        #1;
        check("cfg_blocks_ready", int'(s_ready), 0);
        @(negedge clk);
        cfg_we = 1'b0; s_valid = 1'b0;
        check("word_not_taken", int'(busy), 0);
        expect_m(3, 1); expect_m(7, 2);
        send_word(8'h66, 1'b1, 0, 2);
        expect_m(3, 3); expect_m(7, 4);
        send_word(8'h66, 1'b1, 0, 0);

        // 5: saturation on the 2-bit counter instance
        do_cfg(4'b1010, 1'b1);
        clear_cnt();
        expect_m(3, 1); expect_m(5, 2); expect_m(7, 3);
        send_word(8'hAA, 1'b0, 0, 0);
        expect_m(1, 4); expect_m(3, 5); expect_m(5, 6); expect_m(7, 7);
        send_word(8'hAA, 1'b1, 0, 0);
        check("t5_count8", int'(match_count), 7);
        check("t5_count2_sat", int'(match_count2), 3);

        // 6: cnt_clr on the same edge as the pos-3 hit
        clear_cnt();
        expect_m(3, 0); expect_m(5, 1); expect_m(7, 2);
        send_word(8'hAA, 1'b1, 4, 0);
        check("t6_count2", int'(match_count2), 2);

        // 7: reset on the 4th bit edge aborts the word
        clear_cnt();
        s_valid = 1'b1; s_data = 8'hAA; s_last = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t7_match", int'(match), 0);
        check("t7_busy", int'(busy), 0);
        check("t7_ready_low", int'(s_ready), 0);
        check("t7_count", int'(match_count), 0);
        check("t7_pos", int'(match_pos), 0);
        rst = 1'b1;
        @(negedge clk);
        check("t7_ready_high", int'(s_ready), 1);
        check("t7_match_after", int'(match), 0);
        expect_m(3, 1); expect_m(5, 2); expect_m(7, 3);
        send_word(8'hAA, 1'b1, 0, 0);

        repeat (4) @(negedge clk);
        check("missing_matches", exp_pos.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
